// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART TX serializer between NUM_REQ
// byte-stream requesters.
//
// A byte is accepted from the winning requester through a valid/ready handshake. The
// serializer's start input is then pulsed for one cycle. The arbiter holds off until the
// serializer reports done, plus GAP_CYCLES idle cycles, before it grants again.
//
// Optional feature: define UART_TX_ARB_LOCK_EN for packet lock. A requester keeps the
// grant until it sends a byte flagged with REQ_LAST_I.
//
// Ports:
//   CLK_I        clock, rising edge
//   RST_NI       asynchronous active-low reset
//   REQ_VALID_I  per-requester byte valid
//   REQ_DATA_I   per-requester byte, requester i at [8i+7:8i]
//   REQ_LAST_I   per-requester last-byte-of-packet flag (lock build only)
//   REQ_READY_O  one-hot accept, only ever set in IDLE
//   TX_START_O   one-cycle start pulse to the serializer
//   TX_DATA_O    registered byte for the serializer
//   TX_DONE_I    serializer frame-complete pulse
//   BUSY_O       high whenever the arbiter is not idle
//   GRANT_O      registered index of the last accepted requester
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned GAP_CYCLES = 0,
    localparam int unsigned GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 CLK_I,
    input  logic                 RST_NI,
    input  logic [NUM_REQ-1:0]   REQ_VALID_I,
    input  logic [8*NUM_REQ-1:0] REQ_DATA_I,
    input  logic [NUM_REQ-1:0]   REQ_LAST_I,
    output logic [NUM_REQ-1:0]   REQ_READY_O,
    output logic                 TX_START_O,
    output logic [7:0]           TX_DATA_O,
    input  logic                 TX_DONE_I,
    output logic                 BUSY_O,
    output logic [GW-1:0]        GRANT_O
);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      ptr_q, ptr_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [7:0]         data_q, data_d;
    logic [7:0]         gap_q, gap_d;
    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [GW-1:0]      winner;

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_q, lock_d;

    // The lock owner is always the last accepted requester, which is ptr_q.
    always_comb begin
        eligible = REQ_VALID_I;
        if (lock_q) begin
            eligible = REQ_VALID_I & (NUM_REQ'(1) << ptr_q);
        end
    end
`else
    logic unused_last;
    assign unused_last = ^REQ_LAST_I;

    always_comb begin
        eligible = REQ_VALID_I;
    end
`endif

    // First eligible requester searching upward from ptr+1 with wrap.
    always_comb begin
        logic [GW-1:0] idx;
        found  = 1'b0;
        winner = ptr_q;
        idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((32'(ptr_q) + k) % NUM_REQ);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        data_d      = data_q;
        gap_d       = gap_q;
        REQ_READY_O = '0;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d      = lock_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Ready is gated by reset so it reads 0 while reset is held.
                if (found && RST_NI) begin
                    REQ_READY_O = NUM_REQ'(1) << winner;
                    data_d      = REQ_DATA_I[8*winner +: 8];
                    grant_d     = winner;
                    ptr_d       = winner;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_d      = ~REQ_LAST_I[winner];
`endif
                    state_d     = StStart;
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                if (TX_DONE_I) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                        gap_d   = 8'(GAP_CYCLES - 1);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (gap_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q <= StIdle;
            ptr_q   <= GW'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign TX_START_O = (state_q == StStart);
    assign BUSY_O     = (state_q != StIdle);
    assign TX_DATA_O  = data_q;
    assign GRANT_O    = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (gap 4 and gap 0) share the same requester
// stimulus. A timestamp-based reference model checks every output of both on every cycle,
// and directed phases pin the model with literal expectations.
module tb_uart_tx_arbiter;

    localparam int N   = 3;
    localparam int GW  = 2;
    localparam int DW  = 8 * N;
    localparam int INF = 32'h3fff_ffff;
`ifdef UART_TX_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic          CLK;
    logic          RST_N;
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic [DW-1:0] data;
    logic          done;
    logic [N-1:0]  ready [2];
    logic          start [2];
    logic [7:0]    txd   [2];
    logic          busy  [2];
    logic [GW-1:0] grant [2];

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(4)) dut_a (
        .CLK_I(CLK), .RST_NI(RST_N), .REQ_VALID_I(valid), .REQ_DATA_I(data),
        .REQ_LAST_I(last), .REQ_READY_O(ready[0]), .TX_START_O(start[0]),
        .TX_DATA_O(txd[0]), .TX_DONE_I(done), .BUSY_O(busy[0]), .GRANT_O(grant[0])
    );

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0)) dut_b (
        .CLK_I(CLK), .RST_NI(RST_N), .REQ_VALID_I(valid), .REQ_DATA_I(data),
        .REQ_LAST_I(last), .REQ_READY_O(ready[1]), .TX_START_O(start[1]),
        .TX_DATA_O(txd[1]), .TX_DONE_I(done), .BUSY_O(busy[1]), .GRANT_O(grant[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the arbiter is idle from m_free onward, a start is due the cycle
    // after an accept, and a done counts only once the start cycle has passed.
    int         cyc = 0;
    int         m_free [2];
    int         m_acc  [2];
    int         m_ptr  [2];
    int         m_grant[2];
    logic [7:0] m_data [2];
    bit         m_lock [2];
    bit         mi;
    int         mw;
    int         m_idx;
    logic [N-1:0] mexp;
    string      pfx;

    always @(negedge CLK) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            pfx = (k == 0) ? "a_" : "b_";
            if (!RST_N) begin
                m_free[k] = 0;  m_acc[k] = -100; m_ptr[k] = N - 1;
                m_grant[k] = 0; m_data[k] = 8'h00; m_lock[k] = 1'b0;
                check({pfx, "rst_ready"}, 32'(ready[k]), 0);
                check({pfx, "rst_start"}, 32'(start[k]), 0);
                check({pfx, "rst_busy"},  32'(busy[k]),  0);
                check({pfx, "rst_data"},  32'(txd[k]),   0);
                check({pfx, "rst_grant"}, 32'(grant[k]), 0);
            end else begin
                mi = (cyc >= m_free[k]);
                mw = -1;
                if (mi) begin
                    for (int j = 1; j <= N; j++) begin
                        m_idx = (m_ptr[k] + j) % N;
                        if (mw < 0 && valid[m_idx] &&
                            !(LOCK && m_lock[k] && m_idx != m_ptr[k])) begin
                            mw = m_idx;
                        end
                    end
                end
                mexp = (mw >= 0) ? N'(1 << mw) : '0;
                check({pfx, "ready"}, 32'(ready[k]), 32'(mexp));
                check({pfx, "start"}, 32'(start[k]), 32'(cyc == m_acc[k] + 1));
                check({pfx, "busy"},  32'(busy[k]),  32'(!mi));
                check({pfx, "data"},  32'(txd[k]),   32'(m_data[k]));
                check({pfx, "grant"}, 32'(grant[k]), 32'(m_grant[k]));
                if (mw >= 0) begin
                    m_data[k]  = data[8*mw +: 8];
                    m_grant[k] = mw;
                    m_ptr[k]   = mw;
                    m_acc[k]   = cyc;
                    m_free[k]  = INF;
                    m_lock[k]  = !last[mw];
                end else if (m_free[k] == INF && done && cyc >= m_acc[k] + 2) begin
                    m_free[k] = cyc + 1 + ((k == 0) ? 4 : 0);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge CLK); #1 RST_N = 1'b0;
        valid = '0; last = '0; done = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    task automatic wait_ready(input int k, output logic [N-1:0] w);
        w = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (ready[k] != '0) begin
                w = ready[k];
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_ready: got no ready expected ready within 60 cycles");
    endtask

    task automatic wait_start(input int k);
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (start[k]) return;
        end
        checks++; errors++;
        $display("FAIL wait_start: got no start expected start within 60 cycles");
    endtask

    // Done raised in the 10th cycle after the start cycle just sampled.
    task automatic done_after_10();
        repeat (10) @(posedge CLK);
        #1 done = 1'b1;
        @(posedge CLK);
        #1 done = 1'b0;
    endtask

    logic [7:0]   b0   [3] = '{8'h01, 8'h02, 8'h03};
    bit           l0   [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0]   lexp [4];
    logic [7:0]   got_d[4];
    logic [GW-1:0] got_g[4];
    logic [7:0]   rr_d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA0};
    logic [GW-1:0] rr_g[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [N-1:0] w;
    int           fa, fb, idx;

    initial begin
        RST_N = 1'b0; valid = '0; last = '0; data = '0; done = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_ready", 32'(ready[0]), 0);
        check("reset_start", 32'(start[0]), 0);
        check("reset_data",  32'(txd[0]),   0);
        check("reset_busy",  32'(busy[0]),  0);
        check("reset_grant", 32'(grant[0]), 0);

        // Spurious done in IDLE with nothing valid.
        @(posedge CLK); #1 RST_N = 1'b1; done = 1'b1;
        @(posedge CLK); #1 done = 1'b0;
        @(negedge CLK);
        check("idle_spurious_done_busy", 32'(busy[0]), 0);

        // Single byte from requester 0; spurious done during START.
        @(posedge CLK); #1 valid = 3'b001; data[7:0] = 8'h55;
        @(negedge CLK);
        check("single_ready", 32'(ready[0]), 32'b001);
        @(posedge CLK); #1 valid = '0; done = 1'b1;
        @(negedge CLK);
        check("single_start", 32'(start[0]), 1);
        check("single_data",  32'(txd[0]),   32'h55);
        check("single_busy",  32'(busy[0]),  1);
        @(posedge CLK); #1 done = 1'b0;
        repeat (4) @(negedge CLK);
        check("wait_needs_done", 32'(busy[0]), 1);

        // Gap timing: done in cycle t, next ready at t+5 (gap 4) and t+1 (gap 0).
        @(posedge CLK); #1 valid = 3'b001; done = 1'b1;
        fa = -1; fb = -1;
        @(negedge CLK);
        if (ready[0] != '0) fa = 0;
        if (ready[1] != '0) fb = 0;
        @(posedge CLK); #1 done = 1'b0;
        for (int k = 1; k < 14; k++) begin
            @(negedge CLK);
            if (ready[0] != '0 && fa < 0) fa = k;
            if (ready[1] != '0 && fb < 0) fb = k;
        end
        check("gap4_ready_delay", 32'(fa), 5);
        check("gap0_ready_delay", 32'(fb), 1);
        @(posedge CLK); #1 valid = '0; done = 1'b1;
        @(posedge CLK); #1 done = 1'b0;
        repeat (8) @(posedge CLK);

        // Round-robin with all requesters valid.
        do_reset();
        valid = 3'b111; data = {8'hA2, 8'hA1, 8'hA0};
        for (int t = 0; t < 4; t++) begin
            wait_start(0);
            got_d[t] = txd[0];
            got_g[t] = grant[0];
            done_after_10();
        end
        for (int t = 0; t < 4; t++) begin
            check("rr_data",  32'(got_d[t]), 32'(rr_d[t]));
            check("rr_grant", 32'(got_g[t]), 32'(rr_g[t]));
        end

        // Packet from requester 0 against a waiting requester 1.
        do_reset();
        if (LOCK) lexp = '{8'h01, 8'h02, 8'h03, 8'h10};
        else      lexp = '{8'h01, 8'h10, 8'h02, 8'h10};
        idx = 0;
        valid = 3'b011; last = 3'b010;
        data[7:0] = b0[0]; data[15:8] = 8'h10; last[0] = l0[0];
        for (int t = 0; t < 4; t++) begin
            wait_ready(0, w);
            @(posedge CLK); #1;
            if (w[0]) begin
                idx++;
                if (idx < 3) begin
                    data[7:0] = b0[idx];
                    last[0]   = l0[idx];
                end else begin
                    valid[0] = 1'b0;
                end
            end
            @(negedge CLK);
            got_d[t] = txd[0];
            done_after_10();
        end
        for (int t = 0; t < 4; t++) check("lock_order", 32'(got_d[t]), 32'(lexp[t]));

        // Reset while in WAIT with a packet lock held.
        do_reset();
        valid = 3'b101; data[7:0] = 8'h01; data[23:16] = 8'h22; last = 3'b100;
        wait_ready(0, w);
        check("rw_first_winner", 32'(w), 32'b001);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rw_busy_in_wait", 32'(busy[0]), 1);
        @(posedge CLK); #1 RST_N = 1'b0;
        #1;
        check("rw_busy",  32'(busy[0]),  0);
        check("rw_data",  32'(txd[0]),   0);
        check("rw_grant", 32'(grant[0]), 0);
        check("rw_ready", 32'(ready[0]), 0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("rw_post_reset_winner", 32'(ready[0]), 32'b001);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK); #1;
            valid = N'($urandom);
            if ($urandom_range(0, 3) == 0) valid = '0;
            data = DW'($urandom);
            last = N'($urandom);
            done = ($urandom_range(0, 4) == 0);
        end
        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
